clock_period_meter: RTL
=======================

// Module: clock_period_meter
// PURPOSE
//  Measures a slow, asynchronous clock-like input (e.g. a divided clock) in
//  units of i_clk cycles: rise-to-rise period and high time. It is the
//  measuring end of our clock-division path; it checks that divided clocks
//  are actually running at the expected ratio and duty cycle.
//  Reports one result per input period and flags a timeout when the input
//  stops toggling.
// PARAMETERS
//  CNT_W    16     width of the period/high counters and outputs
//  TIMEOUT  50000  i_clk cycles after the last rise with no new rise -> timeout.
//                  Must satisfy 2 <= TIMEOUT < 2**CNT_W.
// PORTS
//  i_clk      in   1      system clock
//  i_rst_n    in   1      asynchronous active-low reset
//  i_sig      in   1      signal to measure; asynchronous to i_clk
//  i_en       in   1      measurement enable, synchronous to i_clk
//  o_period   out  CNT_W  last measured rise-to-rise period, in i_clk cycles
//  o_high     out  CNT_W  last measured rise-to-fall high time, in i_clk cycles
//  o_valid    out  1      1-cycle pulse; o_period/o_high updated this cycle
//  o_timeout  out  1      level; input stalled (see below)
// BEHAVIOUR
//  Reset: the sync flops, prev, cnt, hi_cap, o_period, o_high, o_valid and
//   o_timeout are all 0, and state = IDLE. Reset takes effect at any time,
//   including mid-measurement.
//  Input path: 2-flop synchronizer s1->s2, then prev<=s2.
//   rise = s2 & ~prev; fall = ~s2 & prev.
//   Edge-detect latency: rise is asserted in the 2nd i_clk cycle after the
//   first i_clk edge that samples i_sig high.
//  The synchronizer and prev run in every state.
//  FSM:
//   IDLE: cnt <= 0. Go to ARM when i_en = 1.
//   ARM:  waits for rise; falls are ignored. On rise: cnt <= 1, go to MEAS.
//         No o_valid is issued.
//   MEAS: cnt <= cnt+1 each cycle.
//     On fall: hi_cap <= cnt.
//     On rise: o_period <= cnt; o_high <= hi_cap; o_valid <= 1 next cycle;
//       o_timeout <= 0; cnt <= 1.
//     Timeout: if cnt == TIMEOUT and there is no rise this cycle:
//       o_timeout <= 1, go to ARM. o_period/o_high hold their values.
//   Any state: i_en = 0 -> go to IDLE next cycle. No o_valid is issued, a
//    partial measurement is discarded, and outputs hold (o_timeout included).
//  Counting rule: rises exactly N cycles apart -> o_period = N. A high phase
//   of H cycles -> o_high = H. Minimum measurable period is 2 (o_high = 1).
//  cnt never exceeds TIMEOUT, so there is no wrap-around or saturation logic.
//  Simultaneous events:
//   - rise with cnt == TIMEOUT: the rise wins (valid result, no timeout).
//   - rise and fall cannot coincide.
//   - i_en falling on a rise cycle: IDLE wins, no o_valid.
//  o_valid is registered; it is never asserted two cycles in a row unless
//   the period is 1, which cannot occur.
// TESTING (TIMEOUT = 300 for the bench)
//  1. i_sig: 50 cycles high, 50 low, repeated; i_en = 1 ->
//     o_valid on every rise from the 2nd rise on; o_period = 100, o_high = 50.
//  2. Change to 30 high / 70 low ->
//     first o_valid after the change: o_high = 30, o_period = 100.
//  3. Hold i_sig low after a rise ->
//     o_timeout = 1 exactly 300 cycles after that rise is detected, no o_valid;
//     then resume at period 100 -> 1st rise: no valid; 2nd rise: valid
//     (100/50) and o_timeout = 0.
//  4. i_sig toggles every i_clk cycle -> o_period = 2, o_high = 1 on each valid.
//  5. Drop i_en for 10 cycles mid-period, then restore ->
//     no o_valid during or immediately after; the first valid comes on the
//     2nd detected rise after i_en = 1.
//  6. Assert i_rst_n = 0 mid-MEAS ->
//     all outputs 0 at once; after release, behaviour is as in scenario 1.

Source files
------------

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures rise-to-rise period and high time of a slow async input in i_clk cycles
// Ports: i_clk system clock; i_rst_n async active-low reset; i_sig measured signal (async);
//        i_en measurement enable; o_period/o_high last period/high time; o_valid result pulse;
//        o_timeout level, set when no rise arrives within TIMEOUT cycles of the last one.
module clock_period_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sig,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_timeout
);
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
  state_t r_state, w_next;
  logic r_s1, r_s2, r_prev;
  logic [CNT_W-1:0] r_cnt, r_hi_cap;
  logic w_rise, w_fall, w_to;
  assign w_rise = r_s2 & ~r_prev;
  assign w_fall = ~r_s2 & r_prev;
  // a rise on the timeout cycle still produces a valid result
  assign w_to = (r_state == MEAS) && !w_rise && (r_cnt == CNT_W'(TIMEOUT));
  always_comb begin
    w_next = r_state;
    if (!i_en) w_next = IDLE;
    else if (r_state == IDLE) w_next = ARM;
    else if (r_state == ARM && w_rise) w_next = MEAS;
    else if (w_to) w_next = ARM;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_prev    <= 1'b0;
      r_cnt     <= '0;
      r_hi_cap  <= '0;
      o_period  <= '0;
      o_high    <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      r_s1    <= i_sig;
      r_s2    <= r_s1;
      r_prev  <= r_s2;
      r_state <= w_next;
      o_valid <= 1'b0;
      if (!i_en || r_state == IDLE) r_cnt <= '0;
      else if (r_state == ARM) begin
        if (w_rise) r_cnt <= CNT_W'(1);
      end else if (w_rise) begin
        o_period  <= r_cnt;
        o_high    <= r_hi_cap;
        o_valid   <= 1'b1;
        o_timeout <= 1'b0;
        r_cnt     <= CNT_W'(1);
      end else if (w_to) o_timeout <= 1'b1;
      else begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_fall) r_hi_cap <= r_cnt;
      end
    end
  end
endmodule
